bcd_convert_arbiter: RTL
========================

# bcd_convert_arbiter

Shares one iterative binary-to-decimal converter among up to N_REQ requesters, such as score, timer and counter sources feeding the seven-segment display path. A round-robin arbiter accepts one request at a time and latches that requester's 16-bit value. The value is converted with a shift-add-3 (double-dabble) sequence, then four BCD digits are returned with a one-cycle done pulse tagged by requester ID. The block sits between the value producers and the display scan/multiplexing logic.

## Interface

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, binary input width per requester (fixed at 16 in this release)
- ID_W, $clog2(N_REQ), requester ID width (derived)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester request; held high until own done seen
- num_flat  in  N_REQ*WIDTH  requester i value at bits [i*WIDTH +: WIDTH]; sampled only at accept
- busy  out  1  high from accept edge until return to IDLE
- done  out  1  one-cycle pulse; digits, ovf and done_id valid while high and held until next accept
- done_id  out  ID_W  index of requester whose result is presented
- digit4, digit3, digit2, digit1  out  4 each  BCD thousands, hundreds, tens, ones
- ovf  out  1  latched value exceeded 9999; digits forced to 9,9,9,9

## Operation

- States: IDLE, CONV, DONE (shared enum).
- IDLE:
  - If req is nonzero, round-robin picks the first set bit starting at last_grant+1 and wrapping.
  - The selected value is latched; values above 9999 are replaced by 9999 with ovf_next=1.
  - The 36-bit shift register {20'b0, value} is loaded, the iteration counter is cleared, last_grant and done_id are set to the winner, and the state goes to CONV.
- CONV, one iteration per cycle: every BCD nibble ≥5 gets +3, then the whole register shifts left by 1. After WIDTH iterations the state goes to DONE.
- Entering DONE registers digit4..digit1 from the low 16 BCD bits. The fifth BCD digit is always 0 due to the clamp. ovf is registered and done=1.
- DONE: done returns to 0 and the state goes to IDLE. No accept happens in DONE.
- A requester dropping req during CONV does not abort; the result is still delivered.
- The arbiter ignores req changes except in IDLE.
- Requests arriving while busy wait. Fairness: a continuously asserting requester waits at most N_REQ−1 conversions.
- Reset values:
  - state=IDLE, last_grant=N_REQ−1 (requester 0 wins first)
  - busy=0, done=0, done_id=0, ovf=0
  - all digits=0, shift register and counter=0
- Reset mid-conversion: the conversion is discarded, no done pulse is issued, and requesters must keep or reassert req.

## Timing

- Accept edge E0; iterations on E1..EWIDTH; done high in the cycle after EWIDTH (latency WIDTH edges from accept).
- done falls at EWIDTH+1 and the state is IDLE. The next accept is possible at EWIDTH+2, giving throughput of one conversion per WIDTH+2 cycles.
- busy rises at E0 and falls at EWIDTH+1.
- done_id changes only at accept edges.

## Configuration

- BCD_ARB_BLANK_EN defined: adds output blank[3:0], registered with the digits in DONE.
  - blank[k]=1 when digit(k+1) and all higher digits are 0, for k=3..1; blank[0] is always 0.
  - Example: 42 gives blank=4'b1100.
  - Reset value 4'b0000.
- Undefined: no blank port and no blanking logic.

## Structure

- Package bcd_arb_pkg holds:
  - state enum {IDLE, CONV, DONE}
  - BCD_DIGITS=4, BCD_MAX=16'd9999, the shift-register width constant
- Sub-module bcd_double_dabble holds the shift register, add-3 correction and iteration counter.
  - Interface: start, value[15:0] → done, digits[15:0].
  - The arbiter FSM and round-robin pointer stay in the top level.

## Test plan

- Single requester: req[0] with num=1234 → after 16 cycles, done=1, done_id=0, digits 1,2,3,4, ovf=0.
- Overflow clamp: req[2] with num=65535 → digits 9,9,9,9, ovf=1, done_id=2; boundary cases 9999 gives ovf=0 and 10000 gives ovf=1.
- Round-robin: all four req held with values 0, 7, 80, 905 → done_id sequence 0,1,2,3,0, each with correct digits; done pulses spaced 18 cycles.
- Zero and blanking: req[1] with num=0 → digits 0,0,0,0; with BCD_ARB_BLANK_EN, blank=4'b1110. For num=42, blank=4'b1100.
- Reset mid-conversion: assert rst 5 cycles after accept → next cycle busy=0 and digits 0; no done pulse. Requester 0 wins first after reset.
- Input change after accept: num_flat for the granted requester changes from 1234 to 4321 during CONV → result still 1,2,3,4.

Source files
------------

// File: rtl/bcd_convert_arbiter_pkg.sv
// rtl/bcd_convert_arbiter_pkg.sv - shared types and constants for the BCD converter arbiter
// Holds the FSM state enum, BCD sizing constants and the leading-zero blank helper.
package bcd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam int BCD_DIGITS = 4;
   localparam logic [15:0] BCD_MAX = 16'd9999;
   // 16 binary bits plus five BCD nibbles; the fifth nibble stays 0 because of the clamp
   localparam int SR_W = 16 + 4 * (BCD_DIGITS + 1);

   function automatic logic [3:0] bcd_blank(input logic [15:0] d);
      return {d[15:12] == 4'd0, d[15:8] == 8'd0, d[15:4] == 12'd0, 1'b0};
   endfunction

endpackage

// File: rtl/bcd_convert_arbiter_if.sv
// rtl/bcd_convert_arbiter_if.sv - requester and result bundle for bcd_convert_arbiter
// The blank field exists only when BCD_ARB_BLANK_EN is defined.
interface bcd_convert_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] num_flat;
   logic                   busy;
   logic                   done;
   logic [ID_W-1:0]        done_id;
   logic [3:0]             digit4;
   logic [3:0]             digit3;
   logic [3:0]             digit2;
   logic [3:0]             digit1;
   logic                   ovf;
`ifdef BCD_ARB_BLANK_EN
   logic [3:0]             blank;

   modport master (
      output req, num_flat,
      input  busy, done, done_id, digit4, digit3, digit2, digit1, ovf, blank
   );
   modport slave (
      input  req, num_flat,
      output busy, done, done_id, digit4, digit3, digit2, digit1, ovf, blank
   );
`else
   modport master (
      output req, num_flat,
      input  busy, done, done_id, digit4, digit3, digit2, digit1, ovf
   );
   modport slave (
      input  req, num_flat,
      output busy, done, done_id, digit4, digit3, digit2, digit1, ovf
   );
`endif

endinterface

// File: rtl/bcd_convert_arbiter_double_dabble.sv
// rtl/bcd_convert_arbiter_double_dabble.sv - iterative shift-add-3 binary to BCD converter
// o_done marks the cycle of the final iteration; o_digits then carries its result.
module bcd_double_dabble
   import bcd_arb_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_done,
   output logic [15:0]      o_digits
);

   logic [SR_W-1:0] r_sr;
   logic [4:0]      r_cnt;
   logic            r_run;
   logic [SR_W-1:0] w_corr;
   logic [SR_W-1:0] w_next;

   always_comb begin
      w_corr = r_sr;
      for (int d = 0; d <= BCD_DIGITS; d++) begin
         if (r_sr[WIDTH + 4*d +: 4] >= 4'd5) begin
            w_corr[WIDTH + 4*d +: 4] = r_sr[WIDTH + 4*d +: 4] + 4'd3;
         end
      end
      w_next = {w_corr[SR_W-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr  <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_start) begin
         r_sr  <= {{(SR_W-WIDTH){1'b0}}, i_value};
         r_cnt <= '0;
         r_run <= 1'b1;
      end else if (r_run) begin
         r_sr  <= w_next;
         r_cnt <= r_cnt + 5'd1;
         if (r_cnt == 5'(WIDTH-1)) begin
            r_run <= 1'b0;
         end
      end
   end

   assign o_done   = r_run && (r_cnt == 5'(WIDTH-1));
   assign o_digits = w_next[WIDTH +: 16];

endmodule

// File: rtl/bcd_convert_arbiter.sv
// rtl/bcd_convert_arbiter.sv - round-robin front end sharing one double-dabble converter
// Defining BCD_ARB_BLANK_EN adds leading-zero blank flags registered with the digits.
module bcd_convert_arbiter
   import bcd_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_convert_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(N_REQ);

   state_t           r_state;
   state_t           w_next_state;
   logic [ID_W-1:0]  r_last_grant;
   logic [ID_W-1:0]  r_done_id;
   logic [ID_W-1:0]  w_grant;
   logic             w_accept;
   logic             w_ovf_next;
   logic             r_ovf_pend;
   logic             r_ovf;
   logic [WIDTH-1:0] w_sel_value;
   logic [WIDTH-1:0] w_load_value;
   logic [15:0]      r_digits;
   logic [15:0]      w_dd_digits;
   logic             w_dd_done;
`ifdef BCD_ARB_BLANK_EN
   logic [3:0]       r_blank;
`endif

   // Scan from farthest to nearest so the nearest set bit after last_grant wins.
   always_comb begin
      w_grant     = r_last_grant;
      w_sel_value = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (bus.req[i] && (((int'(r_last_grant) + k) % N_REQ) == i)) begin
               w_grant = ID_W'(i);
            end
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant == ID_W'(i)) begin
            w_sel_value = bus.num_flat[i*WIDTH +: WIDTH];
         end
      end
      w_ovf_next   = (w_sel_value > BCD_MAX);
      w_load_value = w_ovf_next ? BCD_MAX : w_sel_value;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (|bus.req) begin
               w_accept     = 1'b1;
               w_next_state = CONV;
            end
         end
         CONV:    if (w_dd_done) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= ID_W'(N_REQ-1);
         r_done_id    <= '0;
         r_ovf_pend   <= 1'b0;
         r_ovf        <= 1'b0;
         r_digits     <= '0;
`ifdef BCD_ARB_BLANK_EN
         r_blank      <= 4'b0000;
`endif
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_last_grant <= w_grant;
            r_done_id    <= w_grant;
            r_ovf_pend   <= w_ovf_next;
         end
         if ((r_state == CONV) && w_dd_done) begin
            r_digits <= w_dd_digits;
            r_ovf    <= r_ovf_pend;
`ifdef BCD_ARB_BLANK_EN
            r_blank  <= bcd_blank(w_dd_digits);
`endif
         end
      end
   end

   bcd_double_dabble #(.WIDTH(WIDTH)) u_dd (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_accept),
      .i_value  (w_load_value),
      .o_done   (w_dd_done),
      .o_digits (w_dd_digits)
   );

   assign bus.busy    = (r_state != IDLE);
   assign bus.done    = (r_state == DONE);
   assign bus.done_id = r_done_id;
   assign bus.digit4  = r_digits[15:12];
   assign bus.digit3  = r_digits[11:8];
   assign bus.digit2  = r_digits[7:4];
   assign bus.digit1  = r_digits[3:0];
   assign bus.ovf     = r_ovf;
`ifdef BCD_ARB_BLANK_EN
   assign bus.blank   = r_blank;
`endif

endmodule
